sdram_rdata_64b: RTL and testbench
==================================

# sdram_rdata_64b

Read-side data path of the 64-bit SDRAM controller: the counterpart of the per-bank write data path. It tracks READ commands issued to banks #0-3 through a CAS-latency tag pipeline, then captures the returning burst from the DQ bus. Each captured word is delivered on a shared registered data bus with a one-hot per-bank valid strobe, a word index and a last flag. It sits between the SDRAM pad interface (sdram_dq_i) and the per-bank read clients driven by the command sequencer.

## Interface
- CAS_LAT, 2, SDRAM CAS latency in clocks (legal 2..3)
- BURST_LEN, 4, 64-bit words per READ burst (legal 1, 2, 4, 8)
- clk  input  1  master clock (72 MHz)
- rst_n  input  1  reset, asynchronous, active-low
- rd_issue  input  4  one-hot bank of READ command driven this cycle (p0); all-zero = no read
- sdram_dq_i  input  64  SDRAM data input
- rd_data  output  64  read data word, shared by all banks
- rd_valid  output  4  one-hot: rd_data belongs to bank n this cycle
- rd_idx  output  3  word index within burst (0..BURST_LEN-1)
- rd_last  output  1  final word of burst
- rd_err  output  1  sticky protocol error (see Configuration)

## Operation
- Capture: sdram_dq_i registered every clock into capture reg; capture reg copied to rd_data every clock (no enable). rd_data is don't-care when rd_valid = 0.
- Tag pipeline: rd_issue enters a 4-bit shift line of depth RD_LAT-1, where RD_LAT = CAS_LAT + 3 (1 command output register, CAS_LAT, 1 capture register, 1 output register).
- Burst FSM, states IDLE and BURST:
  - IDLE: tag emerging nonzero -> latch bank, idx = 0, go BURST (or stay IDLE if BURST_LEN = 1, emitting one word).
  - BURST: idx increments each clock; rd_valid = latched bank; rd_last when idx = BURST_LEN-1. At last word: if a new tag emerges the same clock after, seamless reload (idx = 0, new bank); else IDLE.
- Seamless back-to-back reads (issue spacing exactly BURST_LEN) yield continuous rd_valid with no gap, bank switching on the word boundary.
- Illegal cases: issue spacing < BURST_LEN (tag emerges while BURST not at last word) or multi-hot rd_issue. Offending tag dropped; current burst completes unaffected.
- Widths: idx counter 3 bits, wraps only via reload; no arithmetic on data.

## Timing
- rd_issue sampled at edge 0 -> first rd_valid high in the cycle after edge RD_LAT (CAS_LAT = 2: edge 5); data in that cycle = sdram_dq_i sampled at edge RD_LAT-1.
- Words on consecutive clocks; rd_valid high exactly BURST_LEN cycles per accepted read.
- Reset values: rd_data 0, rd_valid 0, rd_idx 0, rd_last 0, rd_err 0, tag line 0, FSM IDLE.
- Reset mid-burst: all outputs clear asynchronously; in-flight tags discarded; no partial burst resumes after release.
- rd_issue is ignored while rst_n is low. The first cycle after release accepts a new issue.

## Configuration
- SDRAM_RD_CHECK_EN defined: illegal spacing or multi-hot rd_issue sets rd_err. It stays set until reset; the offending tag is dropped.
- Undefined: rd_err tied 0. Illegal tags are still dropped; the check logic is absent.

## Structure
- Shared package sdram_pkg: NUM_BANKS = 4, DQ_W = 64, bank one-hot typedef, burst-length legality constants (also used by the write path and the sequencer).
- One sub-module: sdram_rd_tag_pipe, a parameterised 4-bit delay line of depth RD_LAT-1 with async clear.
- Burst FSM, counter and data registers are in the top module.

## Test plan
- CAS 2, BURST 4: rd_issue = 4'b0100 at edge 0, DQ = 0xA0..A3 driven to be sampled at edges 4..7 -> rd_valid = 4'b0100 for 4 cycles starting after edge 5; rd_data A0..A3; rd_idx 0..3; rd_last on A3.
- Seamless: bank0 at edge 0, bank3 at edge 4 -> rd_valid 0001 ×4 then 1000 ×4 with no gap; rd_err = 0.
- Collision: bank1 at edge 0, bank2 at edge 2 -> only bank1 burst (4 words); bank2 never valid; rd_err = 1 with SDRAM_RD_CHECK_EN, 0 without.
- Multi-hot: rd_issue = 4'b0011 -> no rd_valid at all; rd_err = 1 (macro on).
- Reset mid-burst: rst_n low after word 1 of a burst -> outputs 0 immediately. After release, no stale words appear; a new read completes normally.
- CAS 3, BURST 8: single read -> first valid after edge 6; 8 words; rd_last on idx 7.

Source files
------------

// File: rtl/sdram_pkg.sv
// Constants and types shared by the SDRAM controller data paths and command sequencer.
package sdram_pkg;

    localparam int NUM_BANKS = 4;
    localparam int DQ_W      = 64;
    localparam int IDX_W     = 3;

    localparam int BURST_LEN_MIN = 1;
    localparam int BURST_LEN_MAX = 8;

    typedef logic [NUM_BANKS-1:0] bank_oh_t;

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rd_state_e;

    function automatic bit burst_len_legal(input int bl);
        return (bl == 1) || (bl == 2) || (bl == 4) || (bl == 8);
    endfunction

endpackage

// File: rtl/sdram_rd_tag_pipe.sv
// Fixed-depth delay line carrying the one-hot bank tag of each READ until its data returns.
module sdram_rd_tag_pipe
    import sdram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  bank_oh_t tag_i,
    output bank_oh_t tag_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            bank_oh_t q;
            bank_oh_t d;

            if (gi == 0) begin : g_first
                assign d = tag_i;
            end else begin : g_next
                assign d = g_stage[gi-1].q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else begin
                    q <= d;
                end
            end
        end
    endgenerate

    assign tag_o = g_stage[DEPTH-1].q;

endmodule

// File: rtl/sdram_rdata_64b.sv
// SDRAM read data path: tags READs through the CAS latency, then frames the returning burst.
// Optional protocol checking of rd_err is enabled by defining SDRAM_RD_CHECK_EN.
module sdram_rdata_64b
    import sdram_pkg::*;
#(
    parameter int CAS_LAT   = 2,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BANKS-1:0] rd_issue,
    input  logic [DQ_W-1:0]      sdram_dq_i,
    output logic [DQ_W-1:0]      rd_data,
    output logic [NUM_BANKS-1:0] rd_valid,
    output logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_last,
    output logic                 rd_err
);

    // Command register + CAS + capture register + output register.
    localparam int               RD_LAT   = CAS_LAT + 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

    bank_oh_t          tag_emerge;
    logic [DQ_W-1:0]   capture_q;
    logic [DQ_W-1:0]   data_q;
    rd_state_e         state_q, state_d;
    bank_oh_t          bank_q, bank_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    bank_oh_t          valid_q;
    logic [IDX_W-1:0]  idx_out_q;
    logic              last_q;
    logic              tag_any;
    logic              tag_onehot;
    logic              illegal;

    sdram_rd_tag_pipe #(
        .DEPTH(RD_LAT - 1)
    ) u_tag_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .tag_i(rd_issue),
        .tag_o(tag_emerge)
    );

    assign tag_any    = |tag_emerge;
    assign tag_onehot = $onehot(tag_emerge);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture_q <= '0;
            data_q    <= '0;
        end else begin
            capture_q <= sdram_dq_i;
            data_q    <= capture_q;
        end
    end

    // The FSM register stage holds the word that reaches the outputs one clock later.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        idx_d   = idx_q;
        illegal = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (tag_onehot) begin
                    state_d = RD_BURST;
                    bank_d  = tag_emerge;
                    idx_d   = '0;
                end else if (tag_any) begin
                    illegal = 1'b1;
                end
            end
            RD_BURST: begin
                if (idx_q == LAST_IDX) begin
                    if (tag_onehot) begin
                        bank_d = tag_emerge;
                        idx_d  = '0;
                    end else begin
                        state_d = RD_IDLE;
                        illegal = tag_any;
                    end
                end else begin
                    idx_d   = idx_q + 3'd1;
                    illegal = tag_any;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RD_IDLE;
            bank_q    <= '0;
            idx_q     <= '0;
            valid_q   <= '0;
            idx_out_q <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            idx_q     <= idx_d;
            valid_q   <= (state_q == RD_BURST) ? bank_q : '0;
            idx_out_q <= idx_q;
            last_q    <= (state_q == RD_BURST) && (idx_q == LAST_IDX);
        end
    end

`ifdef SDRAM_RD_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (illegal) begin
            err_q <= 1'b1;
        end
    end

    assign rd_err = err_q;
`else
    logic illegal_unused;
    assign illegal_unused = illegal;
    assign rd_err         = 1'b0;
`endif

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
    assign rd_idx   = idx_out_q;
    assign rd_last  = last_q;

endmodule

// File: tb/tb_sdram_rdata_64b.sv
// Scoreboard bench for sdram_rdata_64b: one CAS2/BL4 instance and one CAS3/BL8 instance.
module tb_sdram_rdata_64b;

    localparam int A_LAT = 5;
    localparam int A_BL  = 4;
    localparam int B_LAT = 6;
    localparam int B_BL  = 8;
`ifdef SDRAM_RD_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  a_issue = '0;
    logic [3:0]  b_issue = '0;
    logic [63:0] dq = '0;

    logic [63:0] a_data, b_data;
    logic [3:0]  a_valid, b_valid;
    logic [2:0]  a_idx, b_idx;
    logic        a_last, b_last, a_err, b_err;

    sdram_rdata_64b #(.CAS_LAT(2), .BURST_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_issue(a_issue), .sdram_dq_i(dq),
        .rd_data(a_data), .rd_valid(a_valid), .rd_idx(a_idx), .rd_last(a_last), .rd_err(a_err)
    );

    sdram_rdata_64b #(.CAS_LAT(3), .BURST_LEN(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_issue(b_issue), .sdram_dq_i(dq),
        .rd_data(b_data), .rd_valid(b_valid), .rd_idx(b_idx), .rd_last(b_last), .rd_err(b_err)
    );

    always #5 clk = ~clk;

    // edge_cnt equals n during the cycle after rising edge n.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [3:0]  bank;
        logic [2:0]  idx;
        logic        last;
        logic [63:0] data;
        int          at;
    } word_t;

    word_t q_a[$];
    word_t q_b[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    function automatic logic [63:0] pat(input int n);
        return {16'hDA7A, n[15:0], ~n[15:0], 16'h5A00 ^ n[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_cnt);
    endtask

    // DQ value sampled at edge n is pat(n).
    always @(negedge clk) dq = pat(edge_cnt + 1);

    always @(negedge clk) begin
        word_t e;
        if (a_valid != 4'd0) begin
            if (q_a.size() == 0) begin
                chk("a_spurious", 64'(a_valid), 64'd0);
            end else begin
                e = q_a.pop_front();
                chk("a_valid", 64'(a_valid), 64'(e.bank));
                chk("a_idx",   64'(a_idx),   64'(e.idx));
                chk("a_last",  64'(a_last),  64'(e.last));
                chk("a_data",  a_data,       e.data);
                chk("a_when",  64'(edge_cnt), 64'(e.at));
            end
        end
        if (b_valid != 4'd0) begin
            if (q_b.size() == 0) begin
                chk("b_spurious", 64'(b_valid), 64'd0);
            end else begin
                e = q_b.pop_front();
                chk("b_valid", 64'(b_valid), 64'(e.bank));
                chk("b_idx",   64'(b_idx),   64'(e.idx));
                chk("b_last",  64'(b_last),  64'(e.last));
                chk("b_data",  b_data,       e.data);
                chk("b_when",  64'(edge_cnt), 64'(e.at));
            end
        end
    end

    task automatic push(input bit to_b, input logic [3:0] bank, input int e_edge);
        int    lat = to_b ? B_LAT : A_LAT;
        int    bl  = to_b ? B_BL : A_BL;
        word_t w;
        for (int k = 0; k < bl; k++) begin
            w.bank = bank;
            w.idx  = 3'(k);
            w.last = (k == bl - 1);
            w.data = pat(e_edge + lat - 1 + k);
            w.at   = e_edge + lat + k;
            if (to_b) q_b.push_back(w);
            else q_a.push_back(w);
        end
    endtask

    // Called at a falling edge; the issue is sampled by the next rising edge.
    task automatic issue(input bit to_b, input logic [3:0] bank, input bit ok);
        int e = edge_cnt + 1;
        if (to_b) b_issue = bank;
        else a_issue = bank;
        if (ok) push(to_b, bank, e);
        $display("issue %s bank=%b edge=%0d accepted=%0d", to_b ? "b" : "a", bank, e, ok);
        @(negedge clk);
        a_issue = '0;
        b_issue = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        chk("drain", 64'(q_a.size() + q_b.size()), 64'd0);
    endtask

    task automatic chk_a_clear(input string tag);
        chk({tag, "_valid"}, 64'(a_valid), 64'd0);
        chk({tag, "_data"},  a_data,       64'd0);
        chk({tag, "_idx"},   64'(a_idx),   64'd0);
        chk({tag, "_last"},  64'(a_last),  64'd0);
        chk({tag, "_err"},   64'(a_err),   64'd0);
    endtask

    initial begin
        bit found;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        idle(3);
        chk_a_clear("rst_a");
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_b_data",  b_data,       64'd0);
        chk("rst_b_err",   64'(b_err),   64'd0);
        rst_n = 1'b1;

        // Single read right after reset release
        issue(0, 4'b0100, 1);
        drain();
        idle(4);

        // Seamless back-to-back
        issue(0, 4'b0001, 1);
        idle(3);
        issue(0, 4'b1000, 1);
        drain();
        chk("seamless_err", 64'(a_err), 64'd0);

        // Collision: second tag arrives mid-burst and is dropped
        issue(0, 4'b0010, 1);
        idle(1);
        issue(0, 4'b0100, 0);
        drain();
        idle(8);
        chk("collision_err", 64'(a_err), 64'(ERR_EXP));

        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        chk("err_cleared", 64'(a_err), 64'd0);

        // Multi-hot issue is dropped entirely
        issue(0, 4'b0011, 0);
        idle(12);
        chk("multihot_err", 64'(a_err), 64'(ERR_EXP));

        // Reset in the middle of a burst
        issue(0, 4'b0010, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (a_valid == 4'b0010 && a_idx == 3'd1) found = 1'b1;
        end
        chk("midburst_seen", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_a_clear("midrst");
        q_a.delete();
        idle(3);
        rst_n = 1'b1;
        idle(12);
        issue(0, 4'b1000, 1);
        drain();

        // CAS 3, BURST 8 instance
        issue(1, 4'b0001, 1);
        drain();
        idle(4);
        issue(1, 4'b0100, 1);
        idle(7);
        issue(1, 4'b0010, 1);
        drain();
        chk("b_err", 64'(b_err), 64'd0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
